// File: rtl/regbank_pkg.sv
// regbank_pkg: shared defaults and reset value for the scoreboarded register bank
package regbank_pkg;
    localparam int   DEF_NUM_REGS = 8;
    localparam int   DEF_DATA_W   = 32;
    localparam logic RST_BIT      = 1'b0;
endpackage

// File: rtl/regbank_sb_rdport.sv
// regbank_sb_rdport: one combinational read port with range check and write bypass
// Ports: rd_addr in; regs/busy state in; wr_en (already qualified)/wr_addr/wr_data in;
//        rsv_set/rsv_addr (effective reserve) in; rd_data/rd_busy out.
module regbank_sb_rdport
    import regbank_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rsv_set,
    input  logic [ADDR_W-1:0]   rsv_addr,
    output logic [DATA_W-1:0]   rd_data,
    output logic                rd_busy
);
    logic in_range;
    logic hit;
    always_comb begin
        in_range = 32'(rd_addr) < NUM_REGS;
        hit      = (BYPASS != 0) && wr_en && (wr_addr == rd_addr);
        rd_data  = !in_range ? {DATA_W{RST_BIT}} : hit ? wr_data : regs[rd_addr];
        // a forwarded write clears busy unless a new producer claims it the same cycle
        rd_busy  = in_range && (hit ? (rsv_set && rsv_addr == rd_addr && busy[rd_addr]) : busy[rd_addr]);
    end
endmodule

// File: rtl/regbank_sb.sv
// regbank_sb: NUM_REGS x DATA_W register bank, 2 read ports, 1 write port, busy scoreboard
// Ports: clk, rst_n (async active-low); wr_en/wr_addr/wr_data write port;
//        rd_addrN -> rd_dataN/rd_busyN read ports; rsv_en/rsv_addr -> rsv_ack reserve;
//        busy_cnt registered count of busy registers.
// Option: REGBANK_ZERO_REG_EN makes register 0 read as zero and never busy.
module regbank_sb
    import regbank_pkg::*;
#(
    parameter  int NUM_REGS = DEF_NUM_REGS,
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data1,
    output logic              rd_busy1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ack,
    output logic [ADDR_W:0]   busy_cnt
);
`ifdef REGBANK_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [ADDR_W:0]     busy_cnt_q, busy_cnt_d;
    logic                wr_ok, rsv_set, rsv_zero;

    always_comb begin
        wr_ok    = wr_en && 32'(wr_addr) < NUM_REGS && !(ZERO_REG && wr_addr == '0);
        rsv_zero = ZERO_REG && rsv_addr == '0;
        // a same-cycle write to the reserved register releases it, so the reserve may proceed
        rsv_ack  = rsv_en && 32'(rsv_addr) < NUM_REGS &&
                   (rsv_zero || !busy_q[rsv_addr] || (wr_en && wr_addr == rsv_addr));
        rsv_set  = rsv_ack && !rsv_zero;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = (wr_ok && 32'(wr_addr) == i) ? wr_data : regs_q[i];
            // reserve is applied after release so the new producer wins a collision
            busy_d[i] = (rsv_set && 32'(rsv_addr) == i) || (busy_q[i] && !(wr_ok && 32'(wr_addr) == i));
        end
        busy_cnt_d = (ADDR_W+1)'($countones(busy_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q     <= '{default: {DATA_W{RST_BIT}}};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    regbank_sb_rdport #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
        .rd_addr (rd_addr1), .regs(regs_q), .busy(busy_q),
        .wr_en   (wr_ok), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_set (rsv_set), .rsv_addr(rsv_addr),
        .rd_data (rd_data1), .rd_busy(rd_busy1)
    );

    regbank_sb_rdport #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd2 (
        .rd_addr (rd_addr2), .regs(regs_q), .busy(busy_q),
        .wr_en   (wr_ok), .wr_addr(wr_addr), .wr_data(wr_data),
        .rsv_set (rsv_set), .rsv_addr(rsv_addr),
        .rd_data (rd_data2), .rd_busy(rd_busy2)
    );
endmodule

// File: tb/tb_regbank_sb.sv
// tb_regbank_sb: directed and random checks of regbank_sb against an array-based model
module tb_regbank_sb;
    localparam int N   = 6;
    localparam int DW  = 32;
    localparam int AW  = 3;
    localparam int BYP = 1;
`ifdef REGBANK_ZERO_REG_EN
    localparam bit ZR = 1'b1;
`else
    localparam bit ZR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en, rsv_en, rsv_ack, rd_busy1, rd_busy2;
    logic [AW-1:0] wr_addr, rd_addr1, rd_addr2, rsv_addr;
    logic [DW-1:0] wr_data, rd_data1, rd_data2;
    logic [AW:0]   busy_cnt;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_regs [N];
    bit            m_busy [N];

    regbank_sb #(.NUM_REGS(N), .DATA_W(DW), .BYPASS(BYP)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rsv_ack(rsv_ack),
        .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit wr_hits(input int a);
        return wr_en && int'(wr_addr) == a && a < N && !(ZR && a == 0);
    endfunction

    function automatic bit exp_ack();
        int a = int'(rsv_addr);
        if (!rsv_en || a >= N) return 1'b0;
        if (ZR && a == 0) return 1'b1;
        return !m_busy[a] || (wr_en && int'(wr_addr) == a);
    endfunction

    function automatic bit rsv_takes(input int a);
        return exp_ack() && int'(rsv_addr) == a && !(ZR && a == 0);
    endfunction

    function automatic logic [DW-1:0] exp_data(input int a);
        if (a >= N) return '0;
        if (BYP != 0 && wr_hits(a)) return wr_data;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input int a);
        if (a >= N) return 1'b0;
        if (BYP != 0 && wr_hits(a)) return rsv_takes(a) ? m_busy[a] : 1'b0;
        return m_busy[a];
    endfunction

    function automatic int exp_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) c += int'(m_busy[i]);
        return c;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        wr_en = 0; wr_addr = 0; wr_data = 0;
        rsv_en = 0; rsv_addr = 0;
        rd_addr1 = 0; rd_addr2 = 0;
    endtask

    task automatic tick();
        logic [DW-1:0] nr [N];
        bit            nb [N];
        for (int i = 0; i < N; i++) begin
            nr[i] = m_regs[i];
            nb[i] = m_busy[i];
            if (wr_hits(i)) begin
                nr[i] = wr_data;
                nb[i] = 1'b0;
            end
            if (rsv_takes(i)) nb[i] = 1'b1;
        end
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            m_regs[i] = nr[i];
            m_busy[i] = nb[i];
        end
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        rd_addr1 = 3;
        #1;
        total++; if (busy_cnt !== 0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", busy_cnt); end
        total++; if (rd_data1 !== 0) begin bad++; $display("FAIL reset_data: got %h want 0", rd_data1); end
        wr_en = 1; wr_addr = 3; wr_data = 32'hDEADBEEF;
        rsv_en = 1; rsv_addr = 1;
        #1 tick();
        idle(); rd_addr1 = 3;
        #1;
        total++; if (rd_data1 !== 32'hDEADBEEF) begin bad++; $display("FAIL pre_reset_data: got %h want deadbeef", rd_data1); end
        total++; if (busy_cnt !== 1) begin bad++; $display("FAIL pre_reset_cnt: got %0d want 1", busy_cnt); end
        rst_n = 0;
        model_clear();
        #1;
        total++; if (rd_data1 !== 0) begin bad++; $display("FAIL async_reset_data: got %h want 0", rd_data1); end
        total++; if (busy_cnt !== 0) begin bad++; $display("FAIL async_reset_cnt: got %0d want 0", busy_cnt); end
        wr_en = 1; wr_addr = 4; wr_data = 32'h11; rsv_en = 1; rsv_addr = 2;
        @(posedge clk);
        #1 idle(); rst_n = 1; rd_addr1 = 4; rd_addr2 = 2;
        #1;
        total++; if (rd_data1 !== 0) begin bad++; $display("FAIL reset_drop_write: got %h want 0", rd_data1); end
        total++; if (rd_busy2 !== 0 || busy_cnt !== 0) begin bad++; $display("FAIL reset_drop_rsv: got busy=%0b cnt=%0d want 0 0", rd_busy2, busy_cnt); end
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1; wr_addr = 5; wr_data = 32'h12345678;
        #1 tick();
        idle(); rd_addr1 = 5; rd_addr2 = 5;
        #1;
        total++; if (rd_data1 !== 32'h12345678) begin bad++; $display("FAIL wr_rd_port1: got %h want 12345678", rd_data1); end
        total++; if (rd_data2 !== 32'h12345678) begin bad++; $display("FAIL wr_rd_port2: got %h want 12345678", rd_data2); end
        total++; if (rd_busy1 !== 0 || rd_busy2 !== 0) begin bad++; $display("FAIL wr_rd_busy: got %0b%0b want 00", rd_busy1, rd_busy2); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old2;
        idle();
        old2 = m_regs[2];
        wr_en = 1; wr_addr = 2; wr_data = 32'hA5A5A5A5; rd_addr1 = 2; rd_addr2 = 5;
        #1;
        total++; if (rd_data1 !== (BYP != 0 ? 32'hA5A5A5A5 : old2)) begin bad++; $display("FAIL bypass_data: got %h want %h", rd_data1, (BYP != 0 ? 32'hA5A5A5A5 : old2)); end
        total++; if (rd_data2 !== 32'h12345678) begin bad++; $display("FAIL bypass_other_port: got %h want 12345678", rd_data2); end
        tick();
        idle(); rsv_en = 1; rsv_addr = 3;
        #1 tick();
        idle(); wr_en = 1; wr_addr = 3; wr_data = 32'h77; rd_addr1 = 3;
        #1;
        total++; if (rd_busy1 !== (BYP != 0 ? 1'b0 : 1'b1)) begin bad++; $display("FAIL bypass_busy: got %0b want %0b", rd_busy1, (BYP == 0)); end
        tick();
        idle(); rd_addr1 = 2; rd_addr2 = 3;
        #1;
        total++; if (rd_data1 !== 32'hA5A5A5A5 || rd_data2 !== 32'h77) begin bad++; $display("FAIL bypass_after: got %h %h want a5a5a5a5 77", rd_data1, rd_data2); end
    endtask

    task automatic test_scoreboard();
        idle();
        rsv_en = 1; rsv_addr = 4;
        #1;
        total++; if (rsv_ack !== 1) begin bad++; $display("FAIL sb_ack_first: got %0b want 1", rsv_ack); end
        tick();
        idle(); rd_addr1 = 4; rsv_en = 1; rsv_addr = 4;
        #1;
        total++; if (rd_busy1 !== 1) begin bad++; $display("FAIL sb_busy_set: got %0b want 1", rd_busy1); end
        total++; if (busy_cnt !== 1) begin bad++; $display("FAIL sb_cnt_one: got %0d want 1", busy_cnt); end
        total++; if (rsv_ack !== 0) begin bad++; $display("FAIL sb_ack_busy: got %0b want 0", rsv_ack); end
        tick();
        idle(); wr_en = 1; wr_addr = 4; wr_data = 32'h44;
        #1;
        total++; if (busy_cnt !== 1) begin bad++; $display("FAIL sb_cnt_hold: got %0d want 1", busy_cnt); end
        tick();
        idle(); rd_addr1 = 4;
        #1;
        total++; if (rd_busy1 !== 0 || busy_cnt !== 0) begin bad++; $display("FAIL sb_release: got busy=%0b cnt=%0d want 0 0", rd_busy1, busy_cnt); end
    endtask

    task automatic test_collision();
        int c0;
        idle(); rsv_en = 1; rsv_addr = 5;
        #1 tick();
        c0 = 1;
        idle(); wr_en = 1; wr_addr = 5; wr_data = 32'h55; rsv_en = 1; rsv_addr = 5; rd_addr1 = 5;
        #1;
        total++; if (rsv_ack !== 1) begin bad++; $display("FAIL coll_ack: got %0b want 1", rsv_ack); end
        total++; if (rd_busy1 !== 1) begin bad++; $display("FAIL coll_rd_busy: got %0b want 1", rd_busy1); end
        tick();
        idle(); rd_addr1 = 5;
        #1;
        total++; if (rd_data1 !== 32'h55) begin bad++; $display("FAIL coll_data: got %h want 55", rd_data1); end
        total++; if (rd_busy1 !== 1 || busy_cnt !== c0) begin bad++; $display("FAIL coll_busy: got busy=%0b cnt=%0d want 1 %0d", rd_busy1, busy_cnt, c0); end
        idle(); wr_en = 1; wr_addr = 5; wr_data = 32'h56; rsv_en = 1; rsv_addr = 4;
        #1 tick();
        idle(); rd_addr1 = 5; rd_addr2 = 4;
        #1;
        total++; if (busy_cnt !== c0 || rd_busy1 !== 0 || rd_busy2 !== 1) begin bad++; $display("FAIL swap_net_zero: got cnt=%0d b5=%0b b4=%0b want %0d 0 1", busy_cnt, rd_busy1, rd_busy2, c0); end
        idle(); wr_en = 1; wr_addr = 4; wr_data = 32'h99;
        #1 tick();
    endtask

    task automatic test_range();
        idle();
        wr_en = 1; wr_addr = 7; wr_data = 32'hFFFF_FFFF; rd_addr1 = 7; rd_addr2 = 6;
        rsv_en = 1; rsv_addr = 6;
        #1;
        total++; if (rd_data1 !== 0 || rd_busy1 !== 0) begin bad++; $display("FAIL range_rd7: got %h/%0b want 0/0", rd_data1, rd_busy1); end
        total++; if (rsv_ack !== 0) begin bad++; $display("FAIL range_rsv: got %0b want 0", rsv_ack); end
        tick();
        idle();
        for (int i = 0; i < N; i++) begin
            rd_addr1 = AW'(i);
            #1;
            total++; if (rd_data1 !== m_regs[i]) begin bad++; $display("FAIL range_no_alias r%0d: got %h want %h", i, rd_data1, m_regs[i]); end
        end
        total++; if (busy_cnt !== 0) begin bad++; $display("FAIL range_cnt: got %0d want 0", busy_cnt); end
        idle(); wr_en = 1; wr_addr = 0; wr_data = 32'hFF;
        #1 tick();
        idle(); rd_addr2 = 0;
        #1;
        total++; if (rd_data2 !== (ZR ? 32'h0 : 32'hFF)) begin bad++; $display("FAIL zero_reg: got %h want %h", rd_data2, (ZR ? 32'h0 : 32'hFF)); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_en    = $urandom_range(0, 1);
            wr_addr  = AW'($urandom_range(0, 7));
            wr_data  = $urandom;
            rsv_en   = $urandom_range(0, 1);
            rsv_addr = AW'($urandom_range(0, 7));
            rd_addr1 = $urandom_range(0, 3) == 0 ? wr_addr : AW'($urandom_range(0, 7));
            rd_addr2 = $urandom_range(0, 3) == 0 ? rsv_addr : AW'($urandom_range(0, 7));
            #1;
            total++; if (rd_data1 !== exp_data(int'(rd_addr1))) begin bad++; $display("FAIL rnd_data1 @%0d: got %h want %h", n, rd_data1, exp_data(int'(rd_addr1))); end
            total++; if (rd_data2 !== exp_data(int'(rd_addr2))) begin bad++; $display("FAIL rnd_data2 @%0d: got %h want %h", n, rd_data2, exp_data(int'(rd_addr2))); end
            total++; if (rd_busy1 !== exp_busy(int'(rd_addr1))) begin bad++; $display("FAIL rnd_busy1 @%0d: got %0b want %0b", n, rd_busy1, exp_busy(int'(rd_addr1))); end
            total++; if (rd_busy2 !== exp_busy(int'(rd_addr2))) begin bad++; $display("FAIL rnd_busy2 @%0d: got %0b want %0b", n, rd_busy2, exp_busy(int'(rd_addr2))); end
            total++; if (rsv_ack !== exp_ack()) begin bad++; $display("FAIL rnd_ack @%0d: got %0b want %0b", n, rsv_ack, exp_ack()); end
            total++; if (int'(busy_cnt) !== exp_cnt()) begin bad++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", n, busy_cnt, exp_cnt()); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_range();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
